// File: rtl/protocol_pkg.sv
// Shared definitions for the serial command receiver: parser states, command
// codes, CRC-8 constants and the payload FIFO entry layout.
// Optional build macro: PROTOCOL_RX_CRC8_EN adds the trailing CRC-8 check state.
package protocol_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CMD,
        S_LEN,
        S_DATA
`ifdef PROTOCOL_RX_CRC8_EN
        , S_CRC
`endif
    } state_t;

    localparam logic [4:0] CMD_KEYFRAME = 5'd0;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // FIFO entry: {sof, eof, data[7:0]}
    localparam int ENTRY_W = 10;

    // One serial bit through the CRC-8 shift register, MSB first
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/protocol_fifo.sv
// Synchronous first-word-fall-through FIFO for payload entries.
// Pointers carry one extra wrap bit so full and empty differ only in the MSB.
module protocol_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (wptr == rptr);
    assign o_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = i_pop && !o_empty;
    // A pop frees the head slot in the same cycle, so a push into a full FIFO is still taken
    assign do_push = i_push && (!o_full || do_pop);
    assign o_rdata = o_empty ? '0 : mem[rptr[AW-1:0]];

    // Pointer update; storage itself is not reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Entry storage write
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/protocol_rx.sv
// Serial command receiver: synchronises i_dck/i_cs/i_mosi onto i_clk, parses
// {cmd, len, payload} frames back to back inside one chip-select window and
// streams payload bytes through protocol_fifo.
// Optional build macro: PROTOCOL_RX_CRC8_EN (trailing CRC-8 byte per frame).
module protocol_rx
    import protocol_pkg::*;
#(
    parameter int CMD_W       = 5,
    parameter int LEN_W       = 11,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_dck,
    input  logic             i_cs,
    input  logic             i_mosi,
    output logic             o_hdr_valid,
    output logic [CMD_W-1:0] o_cmd,
    output logic [LEN_W-1:0] o_len,
    output logic             o_valid,
    output logic [7:0]       o_data,
    output logic             o_sof,
    output logic             o_eof,
    input  logic             i_ready,
    output logic             o_abort,
    output logic             o_overflow,
    output logic             o_crc_err,
    output logic             o_busy
);
    localparam int HDR_W  = CMD_W + LEN_W;
    localparam int FMAX   = (CMD_W > LEN_W) ? CMD_W : LEN_W;
    localparam int FCNT_W = $clog2(FMAX + 1);
    localparam logic [FCNT_W-1:0] CMD_LAST = FCNT_W'(CMD_W - 1);
    localparam logic [FCNT_W-1:0] LEN_LAST = FCNT_W'(LEN_W - 1);
`ifdef PROTOCOL_RX_CRC8_EN
    localparam state_t S_END = S_CRC;
`else
    localparam state_t S_END = S_WAIT;
`endif

    function automatic logic [LEN_W-1:0] dec_sat(input logic [LEN_W-1:0] v);
        return (v == '0) ? v : v - LEN_W'(1);
    endfunction

    logic [SYNC_STAGES-1:0] dck_sync, cs_sync, mosi_sync;
    logic                   dck_prev;
    logic                   dck_s, cs_s, mosi_s, bit_rise;

    state_t                 state, state_nx;
    logic [FCNT_W-1:0]      fcnt;
    logic [2:0]             bcnt;
    logic [HDR_W-2:0]       hdr_sr;
    logic [HDR_W-1:0]       hdr_nx;
    logic [LEN_W-1:0]       len_nx;
    logic [6:0]             byte_sr;
    logic [7:0]             byte_nx;
    logic [LEN_W-1:0]       rem;
    logic                   first;
    logic                   hdr_fire, byte_fire, abort_fire, busy;

    logic                   vld_p1;
    logic [ENTRY_W-1:0]     ent_p1;
    logic [ENTRY_W-1:0]     head;
    logic                   fifo_full, fifo_empty, pop, ovf_now;

    assign dck_s    = dck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign bit_rise = dck_s && !dck_prev && !cs_s;
    assign hdr_nx   = {hdr_sr, mosi_s};
    assign len_nx   = hdr_nx[LEN_W-1:0];
    assign byte_nx  = {byte_sr, mosi_s};

    // Input synchronisers and dck edge history; idle link is dck=0, cs=1
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            dck_prev  <= 1'b0;
        end else begin
            dck_sync  <= {dck_sync[SYNC_STAGES-2:0], i_dck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            dck_prev  <= dck_s;
        end
    end

    // Parser state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state decode; cs high returns to idle from anywhere
    always_comb begin
        state_nx = state;
        if (cs_s) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_nx = S_WAIT;
                S_WAIT: if (bit_rise) state_nx = (CMD_W == 1) ? S_LEN : S_CMD;
                S_CMD:  if (bit_rise && fcnt == CMD_LAST) state_nx = S_LEN;
                S_LEN:  if (bit_rise && fcnt == LEN_LAST)
                            state_nx = (len_nx != '0) ? S_DATA : S_END;
                S_DATA: if (bit_rise && bcnt == 3'd7 && rem == LEN_W'(1)) state_nx = S_END;
`ifdef PROTOCOL_RX_CRC8_EN
                S_CRC:  if (bit_rise && bcnt == 3'd7) state_nx = S_WAIT;
`endif
                default: state_nx = S_IDLE;
            endcase
        end
    end

`ifdef PROTOCOL_RX_CRC8_EN
    logic crc_fire;
`endif

    // Output/strobe decode from the current state
    always_comb begin
        busy      = !(state == S_IDLE || state == S_WAIT);
        abort_fire = cs_s && busy;
        hdr_fire  = bit_rise && (state == S_LEN) && (fcnt == LEN_LAST);
        byte_fire = bit_rise && (state == S_DATA) && (bcnt == 3'd7);
`ifdef PROTOCOL_RX_CRC8_EN
        crc_fire  = bit_rise && (state == S_CRC) && (bcnt == 3'd7);
`endif
    end

    assign o_busy = busy;

    // Field shifting, counters, header latch and byte assembly
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fcnt        <= '0;
            bcnt        <= '0;
            hdr_sr      <= '0;
            byte_sr     <= '0;
            rem         <= '0;
            first       <= 1'b0;
            o_cmd       <= '0;
            o_len       <= '0;
            o_hdr_valid <= 1'b0;
            o_abort     <= 1'b0;
            o_overflow  <= 1'b0;
            vld_p1      <= 1'b0;
            ent_p1      <= '0;
        end else begin
            o_hdr_valid <= hdr_fire;
            o_abort     <= abort_fire;
            o_overflow  <= ovf_now;
            // p1: completed byte waits one cycle before entering the FIFO
            vld_p1      <= byte_fire;
            if (cs_s || state == S_IDLE) begin
                fcnt <= '0;
                bcnt <= '0;
            end else if (bit_rise) begin
                case (state)
                    S_WAIT: begin
                        hdr_sr <= hdr_nx[HDR_W-2:0];
                        fcnt   <= (CMD_W == 1) ? FCNT_W'(0) : FCNT_W'(1);
                    end
                    S_CMD: begin
                        hdr_sr <= hdr_nx[HDR_W-2:0];
                        fcnt   <= (fcnt == CMD_LAST) ? FCNT_W'(0) : fcnt + FCNT_W'(1);
                    end
                    S_LEN: begin
                        hdr_sr <= hdr_nx[HDR_W-2:0];
                        if (fcnt == LEN_LAST) begin
                            fcnt  <= '0;
                            bcnt  <= '0;
                            o_cmd <= hdr_nx[HDR_W-1:LEN_W];
                            o_len <= len_nx;
                            rem   <= len_nx;
                            first <= 1'b1;
                        end else begin
                            fcnt <= fcnt + FCNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        byte_sr <= byte_nx[6:0];
                        bcnt    <= bcnt + 3'd1;
                        if (bcnt == 3'd7) begin
                            ent_p1 <= {first, rem == LEN_W'(1), byte_nx};
                            first  <= 1'b0;
                            rem    <= dec_sat(rem);
                        end
                    end
`ifdef PROTOCOL_RX_CRC8_EN
                    S_CRC: begin
                        byte_sr <= byte_nx[6:0];
                        bcnt    <= bcnt + 3'd1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

`ifdef PROTOCOL_RX_CRC8_EN
    logic [7:0] crc_q;

    // Running CRC over header and payload bits; checked against the trailing byte
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            crc_q     <= CRC8_INIT;
            o_crc_err <= 1'b0;
        end else begin
            o_crc_err <= crc_fire && (byte_nx != crc_q);
            if (bit_rise) begin
                case (state)
                    S_WAIT:              crc_q <= crc8_step(CRC8_INIT, mosi_s);
                    S_CMD, S_LEN, S_DATA: crc_q <= crc8_step(crc_q, mosi_s);
                    default: ;
                endcase
            end
        end
    end
`else
    assign o_crc_err = 1'b0;
`endif

    assign pop     = o_valid && i_ready;
    assign ovf_now = vld_p1 && fifo_full && !pop;

    protocol_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (vld_p1),
        .i_wdata (ent_p1),
        .i_pop   (pop),
        .o_rdata (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_valid = !fifo_empty;
    assign o_sof   = head[9];
    assign o_eof   = head[8];
    assign o_data  = head[7:0];

endmodule

// File: tb/tb_protocol_rx.sv
// Self-checking bench for protocol_rx: frame-level reference model (expected
// header/beat queues and pulse counts) compared on every cycle by a monitor.
// Optional build macro: PROTOCOL_RX_CRC8_EN appends and checks the CRC-8 byte.
module tb_protocol_rx;
    localparam int CMD_W = 5;
    localparam int LEN_W = 11;
    localparam int DEPTH = 16;
    localparam int SS    = 2;
    localparam int H     = SS + 3;
    localparam int HDR_W = CMD_W + LEN_W;
`ifdef PROTOCOL_RX_CRC8_EN
    localparam int CRC_BITS = 8;
`else
    localparam int CRC_BITS = 0;
`endif

    logic i_clk = 1'b0;
    logic i_rst_n, i_dck, i_cs, i_mosi, i_ready;
    logic o_hdr_valid, o_valid, o_sof, o_eof, o_abort, o_overflow, o_crc_err, o_busy;
    logic [CMD_W-1:0] o_cmd;
    logic [LEN_W-1:0] o_len;
    logic [7:0] o_data;

    protocol_rx #(.CMD_W(CMD_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_dck(i_dck), .i_cs(i_cs), .i_mosi(i_mosi),
        .o_hdr_valid(o_hdr_valid), .o_cmd(o_cmd), .o_len(o_len), .o_valid(o_valid),
        .o_data(o_data), .o_sof(o_sof), .o_eof(o_eof), .i_ready(i_ready),
        .o_abort(o_abort), .o_overflow(o_overflow), .o_crc_err(o_crc_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [LEN_W-1:0] len;
    } hdr_t;

    int n_checks = 0;
    int n_pass   = 0;
    hdr_t       exp_hdr[$];
    logic [9:0] exp_beat[$];
    hdr_t       hdr_log[$];
    logic [9:0] beat_log[$];
    logic [7:0] payload[$];
    int exp_abort = 0, exp_ovf = 0, exp_crc = 0;
    int got_abort = 0, got_ovf = 0, got_crc = 0;
    int ready_mode = 0;

    function automatic void chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endfunction

    // CRC-8 as the remainder of (message * x^8) mod (x^8+x^2+x+1)
    function automatic logic [7:0] crc_of(input logic m[$]);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < m.size() + 8; i++) begin
            r = {r[7:0], (i < m.size()) ? m[i] : 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    // Consumer ready: 0 = held low, 1 = held high, 2 = random per cycle
    initial begin
        i_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            i_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(1, 0) == 1);
        end
    end

    // Compare process: every cycle, outputs against the model queues
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_hdr_valid) begin
                hdr_log.push_back({o_cmd, o_len});
                if (exp_hdr.size() == 0) chk("hdr_unexpected", 1, 0);
                else begin
                    hdr_t h;
                    h = exp_hdr.pop_front();
                    chk("hdr_cmd", o_cmd, h.cmd);
                    chk("hdr_len", o_len, h.len);
                end
            end
            if (o_valid && i_ready) begin
                beat_log.push_back({o_sof, o_eof, o_data});
                if (exp_beat.size() == 0) chk("beat_unexpected", 1, 0);
                else chk("beat", {o_sof, o_eof, o_data}, exp_beat.pop_front());
            end
            if (o_abort)    got_abort++;
            if (o_overflow) got_ovf++;
            if (o_crc_err)  got_crc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        i_mosi = b;
        wait_cyc(H);
        i_dck = 1'b1;
        wait_cyc(H);
        i_dck = 1'b0;
    endtask

    task automatic cs_start();
        i_cs = 1'b0;
        wait_cyc(SS + 4);
    endtask

    task automatic cs_end();
        wait_cyc(H);
        i_cs = 1'b1;
        wait_cyc(SS + 8);
    endtask

    // Send one frame built from the global payload queue; limit<0 sends all bits.
    // Expectations are queued just before the bit that completes each item.
    task automatic send_frame(input logic [CMD_W-1:0] cmd, input logic [LEN_W-1:0] len,
                              input int limit, input bit crc_flip, input bit cs_cut);
        logic b[$];
        logic [7:0] crc;
        logic [9:0] e;
        int total, k, n;
        for (int i = CMD_W - 1; i >= 0; i--) b.push_back(cmd[i]);
        for (int i = LEN_W - 1; i >= 0; i--) b.push_back(len[i]);
        for (int j = 0; j < int'(len); j++)
            for (int i = 7; i >= 0; i--) b.push_back(payload[j][i]);
        crc = crc_of(b);
        if (crc_flip) crc[0] = ~crc[0];
        for (int i = 7; i >= 0; i--) if (CRC_BITS > 0) b.push_back(crc[i]);
        total = b.size();
        n = (limit < 0 || limit > total) ? total : limit;
        for (int i = 0; i < n; i++) begin
            if (i == HDR_W - 1) exp_hdr.push_back({cmd, len});
            if (i >= HDR_W && i < HDR_W + 8 * int'(len) && (i - HDR_W) % 8 == 7) begin
                k = (i - HDR_W) / 8;
                e = {k == 0, k == int'(len) - 1, payload[k]};
                if (exp_beat.size() >= DEPTH) exp_ovf++;
                else exp_beat.push_back(e);
            end
            if (CRC_BITS > 0 && i == total - 1 && crc_flip) exp_crc++;
            send_bit(b[i]);
        end
        if (cs_cut && n > 0 && n < total) exp_abort++;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        ready_mode = 1;
        while (exp_beat.size() != 0 && t < 500) begin
            wait_cyc(1);
            t++;
        end
        wait_cyc(4);
        chk({name, "_drained"}, exp_beat.size(), 0);
        chk({name, "_fifo_empty"}, o_valid, 0);
        chk({name, "_hdr_all_seen"}, exp_hdr.size(), 0);
        chk({name, "_abort_cnt"}, got_abort, exp_abort);
        chk({name, "_ovf_cnt"}, got_ovf, exp_ovf);
        chk({name, "_crc_cnt"}, got_crc, exp_crc);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_hdr_valid"}, o_hdr_valid, 0);
        chk({name, "_cmd"}, o_cmd, 0);
        chk({name, "_len"}, o_len, 0);
        chk({name, "_valid"}, o_valid, 0);
        chk({name, "_data"}, {o_sof, o_eof, o_data}, 0);
        chk({name, "_abort"}, o_abort, 0);
        chk({name, "_overflow"}, o_overflow, 0);
        chk({name, "_crc_err"}, o_crc_err, 0);
        chk({name, "_busy"}, o_busy, 0);
    endtask

    initial begin
        int ov0, nf, len, lim, tot;
        logic [7:0] tmp [$];
        i_rst_n = 1'b0; i_dck = 1'b0; i_cs = 1'b1; i_mosi = 1'b0;

        // Reset state
        wait_cyc(4);
        check_all_zero("reset");
        i_rst_n = 1'b1;
        wait_cyc(4);

        // Basic frame: cmd 0, len 3, A5 3C FF
        ready_mode = 1;
        hdr_log.delete(); beat_log.delete();
        payload = '{8'hA5, 8'h3C, 8'hFF};
        cs_start();
        send_frame(5'd0, 11'd3, -1, 1'b0, 1'b1);
        cs_end();
        drain("t1");
        chk("t1_nhdr", hdr_log.size(), 1);
        chk("t1_nbeats", beat_log.size(), 3);
        if (hdr_log.size() >= 1) chk("t1_hdr_lit", hdr_log[0], 16'h0003);
        if (beat_log.size() >= 3) begin
            chk("t1_beat0_lit", beat_log[0], 10'h2A5);
            chk("t1_beat1_lit", beat_log[1], 10'h03C);
            chk("t1_beat2_lit", beat_log[2], 10'h1FF);
        end

        // Two frames in one cs window
        hdr_log.delete(); beat_log.delete();
        cs_start();
        payload = '{8'h11};
        send_frame(5'd2, 11'd1, -1, 1'b0, 1'b1);
        payload.delete();
        send_frame(5'd1, 11'd0, -1, 1'b0, 1'b1);
        wait_cyc(3);
        chk("t2_busy_after_hdr", o_busy, 0);
        cs_end();
        drain("t2");
        chk("t2_nhdr", hdr_log.size(), 2);
        if (beat_log.size() >= 1) chk("t2_beat_lit", beat_log[0], 10'h311);
        chk("t2_nbeats", beat_log.size(), 1);

        // Overflow: len 20 into 16 entries with consumer stalled
        ready_mode = 0;
        beat_log.delete();
        ov0 = got_ovf;
        payload.delete();
        for (int i = 0; i < 20; i++) payload.push_back(8'(i));
        cs_start();
        send_frame(5'd3, 11'd20, -1, 1'b0, 1'b1);
        cs_end();
        chk("t3_ovf_lit", got_ovf - ov0, 4);
        chk("t3_valid_held", o_valid, 1);
        chk("t3_head_lit", {o_sof, o_eof, o_data}, 10'h200);
        drain("t3");
        chk("t3_nbeats", beat_log.size(), 16);
        if (beat_log.size() >= 16) chk("t3_last_lit", beat_log[15], 10'h00F);

        // Abort after 4 bits of byte 2 of a len 5 frame
        ready_mode = 0;
        payload = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7};
        cs_start();
        send_frame(5'd4, 11'd5, HDR_W + 8 + 4, 1'b0, 1'b1);
        chk("t4_busy_mid", o_busy, 1);
        ov0 = got_abort;
        cs_end();
        chk("t4_abort_lit", got_abort - ov0, 1);
        chk("t4_head_lit", {o_sof, o_eof, o_data}, 10'h281);
        drain("t4");
        payload = '{8'h5A, 8'hC3};
        cs_start();
        send_frame(5'd6, 11'd2, -1, 1'b0, 1'b1);
        cs_end();
        drain("t4b");

        // Reset pulse mid-payload
        ready_mode = 0;
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        cs_start();
        send_frame(5'd7, 11'd4, HDR_W + 16 + 3, 1'b0, 1'b0);
        chk("t5_valid_before", o_valid, 1);
        i_rst_n = 1'b0;
        wait_cyc(1);
        check_all_zero("t5_rst");
        exp_beat.delete();
        i_rst_n = 1'b1;
        cs_end();
        ready_mode = 1;
        payload = '{8'h99};
        cs_start();
        send_frame(5'd9, 11'd1, -1, 1'b0, 1'b1);
        cs_end();
        drain("t5");

`ifdef PROTOCOL_RX_CRC8_EN
        // CRC good and corrupted
        tmp = '{8'h00, 8'h01, 8'h42};
        begin
            logic m[$];
            foreach (tmp[j]) for (int i = 7; i >= 0; i--) m.push_back(tmp[j][i]);
            chk("crc_model_lit", crc_of(m), 8'hDC);
        end
        ov0 = got_crc;
        payload = '{8'h42};
        beat_log.delete();
        cs_start();
        send_frame(5'd0, 11'd1, -1, 1'b0, 1'b1);
        cs_end();
        chk("t6_crc_ok", got_crc - ov0, 0);
        cs_start();
        send_frame(5'd0, 11'd1, -1, 1'b1, 1'b1);
        cs_end();
        chk("t6_crc_bad", got_crc - ov0, 1);
        drain("t6");
        chk("t6_nbeats", beat_log.size(), 2);
`endif

        // Randomised frames, random consumer back-pressure, occasional aborts
        ready_mode = 2;
        for (int w = 0; w < 10; w++) begin
            cs_start();
            nf = $urandom_range(3, 1);
            for (int f = 0; f < nf; f++) begin
                len = $urandom_range(6, 0);
                payload.delete();
                for (int j = 0; j < len; j++) payload.push_back(8'($urandom));
                tot = HDR_W + 8 * len + CRC_BITS;
                lim = -1;
                if (f == nf - 1 && $urandom_range(3, 0) == 0) lim = $urandom_range(tot - 1, 1);
                send_frame(5'($urandom), 11'(len), lim, 1'($urandom_range(1, 0)), 1'b1);
            end
            cs_end();
            ready_mode = 2;
        end
        drain("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/protocol_rx.md
Name: protocol_rx

Overview:
- Parametrised successor of the lamp serial command receiver.
- Samples the host serial link (i_dck/i_cs/i_mosi) oversampled on i_clk and parses back-to-back frames within one chip-select window.
- Each frame has a header (command, byte length) followed by the payload.
- Header is presented as a one-cycle pulse; payload bytes go through an internal FIFO with a valid/ready stream to the keyframe/framebuffer logic downstream.

Parameters:
- CMD_W, 5, command field width in bits (MSB first on the wire).
- LEN_W, 11, length field width in bits; payload byte count.
- FIFO_DEPTH, 16, payload FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, synchroniser flops on i_dck/i_cs/i_mosi; minimum 2.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_dck  in  1  serial data clock, asynchronous; data sampled on its rising edge.
- i_cs  in  1  chip select, active low, asynchronous.
- i_mosi  in  1  serial data, asynchronous.
- o_hdr_valid  out  1  one-cycle pulse: header complete; o_cmd/o_len valid this cycle.
- o_cmd  out  CMD_W  command of the current frame; held until the next header.
- o_len  out  LEN_W  length of the current frame; held until the next header.
- o_valid  out  1  payload FIFO non-empty.
- o_data  out  8  FIFO head byte.
- o_sof  out  1  FIFO head is the first payload byte of its frame.
- o_eof  out  1  FIFO head is the last payload byte of its frame.
- i_ready  in  1  consumer accepts the head when o_valid is high.
- o_abort  out  1  one-cycle pulse: cs deasserted mid-frame.
- o_overflow  out  1  one-cycle pulse: payload byte dropped because the FIFO was full.
- o_crc_err  out  1  one-cycle pulse on CRC mismatch; tied 0 unless the macro is defined.
- o_busy  out  1  parser not in S_IDLE/S_WAIT.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - All outputs 0; FIFO emptied; state S_IDLE.
  - Synchronisers cleared to idle values: dck=0, cs=1.
- Input path:
  - SYNC_STAGES-flop synchronisers, then a rising-edge detector on synced dck, gated by synced cs=0.
  - Sampled bit is acted on at cycle SYNC_STAGES+1 after the i_dck rise.
  - The host must hold dck high and low each for at least SYNC_STAGES+2 i_clk cycles.
- States: S_IDLE, S_WAIT, S_CMD, S_LEN, S_DATA, S_CRC.
  - S_IDLE: cs high. On synced cs falling -> S_WAIT.
  - S_WAIT: on the first bit -> S_CMD; that bit becomes cmd MSB.
  - S_CMD: after CMD_W bits total -> S_LEN.
  - S_LEN: after LEN_W bits:
    - Pulse o_hdr_valid the same cycle the last bit is acted on; latch o_cmd/o_len.
    - len>0 -> S_DATA.
    - len==0 -> S_CRC if the macro is defined, else S_WAIT.
  - S_DATA: shift MSB first; on each 8th bit, push {sof, eof, byte} into the FIFO the following cycle.
    - sof=1 on the first byte; eof=1 when the remaining count reaches 0.
    - After the last byte -> S_CRC (macro) or S_WAIT; the next frame may start in the same cs window.
- cs rises in any state: -> S_IDLE next cycle.
  - Partial byte/field discarded; bit counters cleared.
  - o_abort pulses if the state was S_CMD/S_LEN/S_DATA/S_CRC.
  - FIFO contents are kept; an aborted frame may lack an eof entry, and the consumer uses o_abort to close it.
- FIFO:
  - First-word-fall-through.
  - Pop when o_valid && i_ready.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push while full with no pop: byte dropped, o_overflow pulses; parsing and the remaining count continue.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguished by the MSB.
- Counters: bit counter 3 bits, wrapping 7->0 per byte; remaining byte count LEN_W bits, decremented on each byte and never below 0.
- Reset mid-frame has the same effect as reset from idle; no pulse outputs are generated.

Optional Feature:
- Macro PROTOCOL_RX_CRC8_EN.
- Defined:
  - Each frame carries a trailing CRC-8 byte: polynomial 0x07, init 0x00, MSB first, covering header bits and payload.
  - S_CRC receives 8 bits, then compares.
  - Mismatch -> o_crc_err pulses one cycle after the 8th bit; state -> S_WAIT either way.
  - The CRC byte is never pushed to the FIFO.
- Undefined: no S_CRC state, no CRC logic, o_crc_err constant 0.

Decomposition:
- Package protocol_pkg: state enum, command codes (CMD_KEYFRAME=0), CRC8 polynomial/init constants, FIFO entry width (10).
- Sub-module protocol_fifo (FIFO_DEPTH, WIDTH): synchronous FWFT FIFO with full/empty flags and the same i_clk/i_rst_n.
- Parser and synchronisers stay in protocol_rx.

Test Plan:
- cmd=0, len=3, bytes A5 3C FF, i_ready=1 -> one o_hdr_valid with cmd 0/len 3; three beats A5(sof) 3C FF(eof).
- Two frames in one cs window, (cmd=2, len=1, 0x11) then (cmd=1, len=0) -> two o_hdr_valid pulses; one beat 0x11 with sof=eof=1; o_busy low after the second header.
- len=20, FIFO_DEPTH=16, i_ready=0 -> first 16 bytes held, 4 o_overflow pulses; after i_ready=1, bytes 0..15 in order.
- cs raised after 4 bits of byte 2 of a len=5 frame -> one o_abort pulse; FIFO holds byte 1 only; next frame parses cleanly.
- i_rst_n low for 1 cycle mid-payload -> all outputs 0, o_valid 0, no o_abort; next frame parses correctly.
- Macro defined: frame cmd=0, len=1, 0x42 with correct CRC -> no o_crc_err; same frame with CRC bit 0 flipped -> one o_crc_err pulse; payload 0x42 delivered in both cases.
